// File: rtl/arb_pkg.sv
// Shared types and constants for the two-source round-robin arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    // Mux select encoding: sel_out drives the downstream 2:1 mux directly.
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/pipe_reg.sv
// One-entry output register with valid/ready: loads on accept, empties when drained.
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         drain,
    output logic         valid,
    output logic [W-1:0] data
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rr_arb_2to1.sv
// Two-source round-robin arbiter with bounded bursts feeding a registered output stage.
module rr_arb_2to1
    import arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              a_valid_in,
    input  logic [DATA_W-1:0] a_data_in,
    output logic              a_ready_out,
    input  logic              b_valid_in,
    input  logic [DATA_W-1:0] b_data_in,
    output logic              b_ready_out,
    output logic              y_valid_out,
    output logic [DATA_W-1:0] y_data_out,
    input  logic              y_ready_in,
    output logic              sel_out
);

    localparam logic [CNT_W-1:0] BURST_END = CNT_W'(BURST_MAX);

    state_t            state, state_nxt;
    logic              last_grant, last_grant_nxt;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt, cnt_inc;
    logic              free, accept_a, accept_b, accept;
    logic              own_valid, other_valid;

    // The output slot can take a new beat when empty or being consumed this cycle.
    assign free        = !y_valid_out || y_ready_in;
    assign a_ready_out = (state == GRANT_A) && free;
    assign b_ready_out = (state == GRANT_B) && free;
    assign accept_a    = a_ready_out && a_valid_in;
    assign accept_b    = b_ready_out && b_valid_in;
    assign accept      = accept_a || accept_b;
    assign cnt_inc     = beat_cnt + 1'b1;
    assign own_valid   = (state == GRANT_B) ? b_valid_in : a_valid_in;
    assign other_valid = (state == GRANT_B) ? a_valid_in : b_valid_in;
    assign sel_out     = (state == GRANT_B) ? SEL_B : SEL_A;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            last_grant <= SEL_B;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_nxt      = state;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        case (state)
            IDLE: begin
                // A wins a tie only when B was the previous winner.
                if (a_valid_in && (!b_valid_in || last_grant == SEL_B)) begin
                    state_nxt      = GRANT_A;
                    last_grant_nxt = SEL_A;
                    beat_cnt_nxt   = '0;
                end else if (b_valid_in) begin
                    state_nxt      = GRANT_B;
                    last_grant_nxt = SEL_B;
                    beat_cnt_nxt   = '0;
                end
            end
            GRANT_A, GRANT_B: begin
                if (!own_valid) begin
                    state_nxt = IDLE;
                end else if (accept) begin
                    if (cnt_inc == BURST_END) begin
                        beat_cnt_nxt = '0;
                        if (other_valid) begin
                            state_nxt      = (state == GRANT_A) ? GRANT_B : GRANT_A;
                            last_grant_nxt = (state == GRANT_A) ? SEL_B : SEL_A;
                        end
                    end else begin
                        beat_cnt_nxt = cnt_inc;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    pipe_reg #(
        .W (DATA_W)
    ) u_out (
        .clk       (clk_in),
        .rst       (rst_in),
        .load      (accept),
        .load_data (accept_b ? b_data_in : a_data_in),
        .drain     (y_ready_in),
        .valid     (y_valid_out),
        .data      (y_data_out)
    );

endmodule

// File: doc/rr_arb_2to1.md
# rr_arb_2to1

- Two-source round-robin arbiter with valid/ready handshakes and a registered output stage.
- Sits directly upstream of the team's 2:1 select mux and decides which of the two input streams (A or B) is forwarded.
- `sel_out` uses the mux select convention: 0 selects A, 1 selects B. It can drive the mux select directly.
- Bounded bursts guarantee fairness when both sources stream continuously.

## Interface
Parameters:
- `DATA_W`, 8: payload width of each source and of the output.
- `BURST_MAX`, 4: maximum consecutive beats granted to one source while the other is requesting. Legal range 1..15.

Ports:
- `clk_in`  in  1  single clock, rising edge.
- `rst_in`  in  1  asynchronous, active-high reset.
- `a_valid_in`  in  1  source A has a beat.
- `a_data_in`  in  DATA_W  source A payload.
- `a_ready_out`  out  1  beat from A accepted this cycle when high together with `a_valid_in`.
- `b_valid_in`  in  1  source B has a beat.
- `b_data_in`  in  DATA_W  source B payload.
- `b_ready_out`  out  1  beat from B accepted this cycle when high together with `b_valid_in`.
- `y_valid_out`  out  1  output beat present.
- `y_data_out`  out  DATA_W  output payload.
- `y_ready_in`  in  1  downstream consumes the output beat when high with `y_valid_out`.
- `sel_out`  out  1  current grant: 1 only in GRANT_B, otherwise 0.

## Operation
States: IDLE, GRANT_A, GRANT_B. Internal registers: `last_grant` (1 bit) and `beat_cnt` (4 bits).

- **Free condition:** `free = !y_valid_out || y_ready_in`.
- **Ready outputs:**
  - `a_ready_out = (state==GRANT_A) && free`.
  - `b_ready_out = (state==GRANT_B) && free`.
  - Both are 0 in IDLE.
- **Accept:** a beat is accepted when the granted source's valid and ready are both high.
- **IDLE transitions:**
  - Only A valid → GRANT_A.
  - Only B valid → GRANT_B.
  - Both valid → grant the side opposite `last_grant`.
  - Neither valid → stay in IDLE.
  - Entering any GRANT state sets `last_grant` to that side and clears `beat_cnt`.
- **GRANT_x transitions:**
  - Granted valid low → IDLE next cycle, regardless of the other source.
  - On accept, `beat_cnt` increments.
  - If the incremented count equals BURST_MAX and the other source is valid → switch directly to GRANT_other, `beat_cnt` = 0, `last_grant` updated.
  - If the incremented count equals BURST_MAX and the other source is not valid → stay in GRANT_x, `beat_cnt` = 0.
  - Stalled cycle (`free` = 0) → no count change, no state change.
- **Output register:**
  - On accept: `y_data_out` ← accepted payload, `y_valid_out` ← 1.
  - Else if `y_ready_in`: `y_valid_out` ← 0.
  - `y_data_out` holds its value whenever no accept occurs, including while stalled.
- **Ordering and loss:** beats are never dropped or duplicated, and order within each source is preserved.

## Timing
- **Reset values:** state IDLE, `last_grant` = 1 (so A wins the first tie), `beat_cnt` = 0, `y_valid_out` = 0, `y_data_out` = 0, `sel_out` = 0, `a_ready_out` = 0, `b_ready_out` = 0.
- **Reset mid-transfer:** asserting `rst_in` discards any held output beat immediately. No partial state survives.
- **Latency from IDLE:** valid sampled in IDLE at cycle N → ready high at N+1 (output free) → `y_valid_out` high at N+2. This costs one bubble per arbitration from IDLE.
- **Streaming throughput:** one beat per cycle while granted and `y_ready_in` is held high.
- **Direct switch at burst end:** no bubble. The other source's ready rises in the cycle after the last beat.
- **Registered `sel_out`:** it changes in the same edge as the state. It is not combinational from the inputs.
- **Valid-low exit:** if the granted source drops valid in the same cycle the other raises it, IDLE is visited for one cycle before the other is granted.

## Structure
- **Package `arb_pkg`:** state enum (IDLE, GRANT_A, GRANT_B), constants `SEL_A` = 0 and `SEL_B` = 1, and the `beat_cnt` width.
- **Sub-module `pipe_reg`:** a one-entry output register with valid/ready, instantiated once. The FSM and counter stay in the top module.

## Test plan
1. **Reset and first grant:** assert `rst_in` mid-stream with `y_valid_out` = 1. Then raise only A with data 0x11, 0x22, 0x33 and hold `y_ready_in` = 1.
   - During reset: all outputs at their reset values.
   - After reset: `y_data_out` shows 0x11, 0x22, 0x33 on consecutive cycles, the first at N+2.
   - `sel_out` = 0 throughout.
2. **Tie fairness:** A and B both stream continuously with BURST_MAX = 4 and the sink always ready.
   - Output pattern is 4 A beats, 4 B beats, 4 A beats, with no bubble at the switches.
   - `sel_out` toggles at each 4-beat boundary.
3. **Backpressure:** hold `y_ready_in` = 0 for 5 cycles while A is granted with a beat held.
   - `y_data_out` is stable, `a_ready_out` = 0, and `beat_cnt` does not advance.
   - On release, the next beat follows with no loss.
4. **Lone source past BURST_MAX:** only B streams 10 beats.
   - All 10 beats pass back-to-back.
   - State stays GRANT_B and `sel_out` stays 1.
5. **Valid-drop exit:** A drops valid after 2 beats while B raises valid in the same cycle.
   - One IDLE cycle (`sel_out` = 0, both readies 0), then GRANT_B.
   - B's first beat appears on `y_data_out` 2 cycles after the IDLE cycle.
